// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator that reads a double-buffered frame store and
// drives registered RGB/sync pins aligned to the returned pixel data.
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 4,
  parameter int RD_LATENCY = 1,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          rd_en,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  output logic          rd_buf,
  input  logic [11:0]   rd_pixel,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          frame_start
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic buf_q, buf_d;
  logic [31:0] hx, vx;
  logic tick, active, hs_raw, vs_raw, h_wrap, v_wrap;
  logic [RD_LATENCY-1:0] pv_q, pa_q, phs_q, pvs_q;
  logic [11:0] rgb_q;
  logic hs_q, vs_q;
  always_comb begin
    hx = 32'(h_q);
    vx = 32'(v_q);
    tick = div_q == '0;
    active = hx < H_ACTIVE && vx < V_ACTIVE;
    hs_raw = !(hx >= H_ACTIVE + H_FP && hx < H_ACTIVE + H_FP + H_SYNC);
    vs_raw = !(vx >= V_ACTIVE + V_FP && vx < V_ACTIVE + V_FP + V_SYNC);
    h_wrap = hx == H_TOTAL - 1;
    v_wrap = vx == V_TOTAL - 1;
    div_d = 32'(div_q) == CLK_DIV - 1 ? '0 : div_q + 1'b1;
    h_d = tick ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
    v_d = (tick && h_wrap) ? (v_wrap ? '0 : v_q + 1'b1) : v_q;
    swap_ack = tick && h_wrap && v_wrap && swap_req;
    buf_d = buf_q ^ swap_ack;
  end
  assign rd_en = tick && active;
  assign rd_x = h_q;
  assign rd_y = v_q;
  assign rd_buf = buf_q;
  assign frame_start = tick && h_q == '0 && v_q == '0;
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DW'(CLK_DIV - 1);
      h_q <= '0;
      v_q <= '0;
      buf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q <= h_d;
      v_q <= v_d;
      buf_q <= buf_d;
    end
  end
  // Tick flags ride a RD_LATENCY-deep delay line so sync and RGB register on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      pa_q <= '0;
      phs_q <= '1;
      pvs_q <= '1;
      rgb_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      pv_q[0] <= tick;
      pa_q[0] <= active;
      phs_q[0] <= hs_raw;
      pvs_q[0] <= vs_raw;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        phs_q[i] <= phs_q[i-1];
        pvs_q[i] <= pvs_q[i-1];
      end
      if (pv_q[RD_LATENCY-1]) begin
        rgb_q <= pa_q[RD_LATENCY-1] ? rd_pixel : 12'h000;
        hs_q <= phs_q[RD_LATENCY-1];
        vs_q <= pvs_q[RD_LATENCY-1];
      end
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: randomized swap/reset stimulus checked every clock against an
// arithmetic timing model derived from the cycle number since reset release.
module tb_vga_scanout;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int CD = 2, L = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT * CD;
  logic clk = 0, rst_n = 0, swap_req = 0;
  logic swap_ack, rd_en, rd_buf, vga_hs, vga_vs, frame_start;
  logic [3:0] rd_x;
  logic [2:0] rd_y;
  logic [11:0] rd_pixel = '0;
  logic [3:0] vga_r, vga_g, vga_b;
  int errors = 0, checks = 0;
  logic buf_m = 0;
  int due_q[$];
  logic [11:0] pix_q[$];

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .swap_req(swap_req), .swap_ack(swap_ack),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_buf(rd_buf), .rd_pixel(rd_pixel),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_xy"}, {rd_x, rd_y}, 0);
    check({tag, "_rd_buf"}, rd_buf, 0);
    check({tag, "_swap_ack"}, swap_ack, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    check({tag, "_syncs"}, {vga_hs, vga_vs}, 2'b11);
  endtask

  task automatic do_reset();
    rst_n = 0;
    swap_req = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset("in_rst");
    rst_n = 1;
    due_q.delete();
    pix_q.delete();
    buf_m = 0;
    #1 chk_reset("cycle0");
  endtask

  // mode 0: request at cycle 50 dropped after ack; 1: request held; 2: random requests
  task automatic run(input int n, input int mode, input int rst_at);
    int reads, p, h, v, q, hq, vq;
    bit drop, tick, act, ack_e, hs_e, vs_e;
    logic [11:0] rgb_e;
    reads = 0;
    drop = 0;
    swap_req = (mode == 1);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (due_q.size() > 0 && due_q[0] == c) begin
        void'(due_q.pop_front());
        rd_pixel = pix_q.pop_front();
      end else rd_pixel = 12'($urandom);
      if (mode == 0 && c == 50) swap_req = 1;
      if (mode == 2 && !swap_req && $urandom_range(0, 59) == 0) swap_req = 1;
      if (drop) begin
        swap_req = 0;
        drop = 0;
      end
      if (c == rst_at) begin
        swap_req = 1;
        rst_n = 0;
        #1 chk_reset("async");
        return;
      end
      #1;
      tick = ((c - 1) % CD) == 0;
      p = (c - 1) / CD;
      h = p % HT;
      v = (p / HT) % VT;
      act = h < HA && v < VA;
      ack_e = tick && h == HT - 1 && v == VT - 1 && swap_req;
      check("rd_en", rd_en, tick && act);
      if (tick && act) begin
        check("rd_x", rd_x, h);
        check("rd_y", rd_y, v);
      end
      check("frame_start", frame_start, tick && h == 0 && v == 0);
      check("swap_ack", swap_ack, ack_e);
      check("rd_buf", rd_buf, buf_m);
      if (c < L + 2) begin
        rgb_e = 0;
        hs_e = 1;
        vs_e = 1;
      end else begin
        q = (c - L - 2) / CD;
        hq = q % HT;
        vq = (q / HT) % VT;
        hs_e = !(hq >= HA + HF && hq < HA + HF + HS);
        vs_e = !(vq >= VA + VF && vq < VA + VF + VS);
        rgb_e = (hq < HA && vq < VA) ? {4'(hq), 4'(vq), buf_m ? 4'h5 : 4'hA} : 12'h000;
      end
      check("rgb", {vga_r, vga_g, vga_b}, rgb_e);
      check("vga_hs", vga_hs, hs_e);
      check("vga_vs", vga_vs, vs_e);
      if (rd_en) begin
        if (c <= FRAME) reads++;
        due_q.push_back(c + L);
        pix_q.push_back({rd_x, 1'b0, rd_y, rd_buf ? 4'h5 : 4'hA});
      end
      if (ack_e) begin
        buf_m = ~buf_m;
        if (mode == 0 || (mode == 2 && $urandom_range(0, 1) == 1)) drop = 1;
      end
    end
    if (mode == 0 && n >= FRAME) check("reads_per_frame", reads, HA * VA);
  endtask

  initial begin
    do_reset();
    run(500, 0, -1);
    do_reset();
    run(2 * FRAME + 40, 1, -1);
    do_reset();
    run(150, 1, 100);
    do_reset();
    run(400, 1, 300);
    do_reset();
    run(300, 0, -1);
    for (int k = 0; k < 3; k++) begin
      do_reset();
      run(600 + $urandom_range(0, 200), 2, $urandom_range(0, 1) ? $urandom_range(60, 700) : -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
